// File: rtl/operand_issue_pkg.sv
// operand_issue_pkg: shared widths, register constants and control-bundle layout for the issue stage
package operand_issue_pkg;
  localparam int XLEN = 32;
  localparam int CTRL_W = 16;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int CTRL_UNIT_LSB = 0;
  localparam int CTRL_UNIT_W = 4;
  localparam int CTRL_OP_LSB = 4;
  localparam int CTRL_OP_W = 6;
  localparam int CTRL_FLAGS_LSB = 10;
  localparam int CTRL_FLAGS_W = 6;
  function automatic logic live_reg(input logic [4:0] idx);
    return idx != REG_ZERO;
  endfunction
  function automatic logic [CTRL_UNIT_W-1:0] ctrl_unit(input logic [CTRL_W-1:0] c);
    return c[CTRL_UNIT_LSB +: CTRL_UNIT_W];
  endfunction
  function automatic logic [CTRL_OP_W-1:0] ctrl_op(input logic [CTRL_W-1:0] c);
    return c[CTRL_OP_LSB +: CTRL_OP_W];
  endfunction
  function automatic logic [CTRL_FLAGS_W-1:0] ctrl_flags(input logic [CTRL_W-1:0] c);
    return c[CTRL_FLAGS_LSB +: CTRL_FLAGS_W];
  endfunction
endpackage

// File: rtl/operand_bypass.sv
// operand_bypass: resolves one source operand from x0, same-cycle writebacks or the regfile
module operand_bypass
  import operand_issue_pkg::*;
#(
  parameter int XLEN = operand_issue_pkg::XLEN
) (
  input  logic [4:0]      idx,
  input  logic [XLEN-1:0] rf_data,
  input  logic            rf_valid,
  input  logic [4:0]      wreg0,
  input  logic [4:0]      wreg1,
  input  logic [XLEN-1:0] wdata0,
  input  logic [XLEN-1:0] wdata1,
  input  logic            wen0,
  input  logic            wen1,
  output logic [XLEN-1:0] value,
  output logic            ready
);
  logic hit0, hit1, zero;
  always_comb begin
    zero = !live_reg(idx);
    hit0 = wen0 && wreg0 == idx;
    hit1 = wen1 && wreg1 == idx;
    // port 0 wins over port 1, matching the regfile's last-write order
    value = zero ? '0 : hit0 ? wdata0 : hit1 ? wdata1 : rf_data;
    ready = zero | hit0 | hit1 | rf_valid;
  end
endmodule

// File: rtl/operand_issue.sv
// operand_issue: reads and bypasses operands, stalls on scoreboard hazards, reserves rd
// and registers the instruction into a single output stage for execute.
module operand_issue
  import operand_issue_pkg::*;
#(
  parameter int XLEN = operand_issue_pkg::XLEN,
  parameter int CTRL_W = operand_issue_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [XLEN-1:0]   dec_pc,
  input  logic [4:0]        dec_rs1,
  input  logic [4:0]        dec_rs2,
  input  logic [4:0]        dec_rd,
  input  logic              dec_use_rs1,
  input  logic              dec_use_rs2,
  input  logic              dec_wr_rd,
  input  logic [XLEN-1:0]   dec_imm,
  input  logic [CTRL_W-1:0] dec_ctrl,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  input  logic              rs1_valid,
  input  logic              rs2_valid,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  output logic [4:0]        rd,
  output logic              reserve,
  input  logic [4:0]        wreg0,
  input  logic [4:0]        wreg1,
  input  logic [XLEN-1:0]   wdata0,
  input  logic [XLEN-1:0]   wdata1,
  input  logic              wen0,
  input  logic              wen1,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rd,
  output logic              ex_wr_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       stall_count
);
  logic [XLEN-1:0] val1, val2;
  logic rdy1, rdy2, clash, space, issue;
  operand_bypass #(.XLEN(XLEN)) u_src1 (
    .idx(dec_rs1), .rf_data(rs1_data), .rf_valid(rs1_valid),
    .wreg0(wreg0), .wreg1(wreg1), .wdata0(wdata0), .wdata1(wdata1),
    .wen0(wen0), .wen1(wen1), .value(val1), .ready(rdy1)
  );
  operand_bypass #(.XLEN(XLEN)) u_src2 (
    .idx(dec_rs2), .rf_data(rs2_data), .rf_valid(rs2_valid),
    .wreg0(wreg0), .wreg1(wreg1), .wdata0(wdata0), .wdata1(wdata1),
    .wen0(wen0), .wen1(wen1), .value(val2), .ready(rdy2)
  );
  always_comb begin
    rs1 = dec_rs1;
    rs2 = dec_rs2;
    rd = dec_rd;
    // a writeback to rd lands after the reservation and would silently clear it
    clash = dec_wr_rd && live_reg(dec_rd) &&
            ((wen0 && wreg0 == dec_rd) || (wen1 && wreg1 == dec_rd));
    space = !ex_valid || ex_ready;
    dec_ready = space && (!dec_use_rs1 || rdy1) && (!dec_use_rs2 || rdy2) && !clash;
    issue = dec_valid && dec_ready;
    reserve = issue && dec_wr_rd && live_reg(dec_rd) && !reset;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_pc <= '0;
      ex_op1 <= '0;
      ex_op2 <= '0;
      ex_imm <= '0;
      ex_rd <= '0;
      ex_wr_rd <= 1'b0;
      ex_ctrl <= '0;
    end else if (issue) begin
      ex_valid <= 1'b1;
      ex_pc <= dec_pc;
      ex_op1 <= val1;
      ex_op2 <= val2;
      ex_imm <= dec_imm;
      ex_rd <= dec_rd;
      ex_wr_rd <= dec_wr_rd;
      ex_ctrl <= dec_ctrl;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_count <= '0;
    else if (dec_valid && !dec_ready && !(&stall_count)) stall_count <= stall_count + 32'd1;
  end
endmodule

// File: doc/operand_issue.md
Name: operand_issue

Overview:
- Issue stage between decode and execute; sits directly upstream of the register file and consumes its read ports and scoreboard valid bits.
- Reads rs1/rs2 and bypasses same-cycle writebacks from both write ports.
- Stalls on scoreboard hazards, then reserves rd and registers operands into one output pipeline register for execute.

Parameters:
- XLEN, 32, datapath width
- CTRL_W, 16, opaque control bundle width passed decode -> execute untouched

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- dec_valid  in  1  decode holds an instruction
- dec_ready  out  1  stage accepts the decode instruction this cycle
- dec_pc  in  XLEN  instruction PC
- dec_rs1, dec_rs2, dec_rd  in  5 each  register indices
- dec_use_rs1, dec_use_rs2, dec_wr_rd  in  1 each  operand use / destination write flags
- dec_imm  in  XLEN  immediate
- dec_ctrl  in  CTRL_W  control bundle
- rs1, rs2  out  5 each  regfile read indices (= dec_rs1/dec_rs2, combinational)
- rs1_valid, rs2_valid  in  1 each  regfile scoreboard bits
- rs1_data, rs2_data  in  XLEN each  regfile read data
- rd  out  5  reservation index
- reserve  out  1  reserve rd this cycle
- wreg0, wreg1  in  5 each  writeback indices (same nets as the regfile write ports)
- wdata0, wdata1  in  XLEN each  writeback data
- wen0, wen1  in  1 each  writeback enables
- ex_valid  out  1  output register holds an instruction
- ex_ready  in  1  execute consumes the output register
- ex_pc, ex_op1, ex_op2, ex_imm  out  XLEN each  registered outputs
- ex_rd  out  5  registered destination
- ex_wr_rd  out  1  registered destination-write flag
- ex_ctrl  out  CTRL_W  registered control
- stall_count  out  32  cycles with dec_valid=1 and dec_ready=0

Behaviour:
- Reset (async, active-high):
  - ex_valid=0; all ex_* data outputs=0; stall_count=0.
  - reserve low while reset is asserted.
- Operand resolution, per source s in {1,2}, with index x:
  - x=0: value 0, ready.
  - Else if wen0 && wreg0==x: wdata0, ready.
  - Else if wen1 && wreg1==x: wdata1, ready. Port 0 has priority when both match, matching regfile last-write order.
  - Else: rs_data, ready = rs_valid.
  - An unused source (dec_use_s=0) is always ready; its value is still forwarded.
- WAR/WAW-reserve clash:
  - If dec_wr_rd && dec_rd!=0 && dec_rd matches an enabled wreg0 or wreg1 this cycle, issue is blocked for that cycle.
  - Reason: the regfile applies the writeback after reserve, so the new reservation would be lost.
- space = ~ex_valid | ex_ready.
- dec_ready = space & src1_ready & src2_ready & ~clash.
  - Combinational; must not depend on dec_valid.
- issue = dec_valid & dec_ready.
  - reserve = issue & dec_wr_rd & (dec_rd!=0); rd = dec_rd (driven regardless of reserve).
  - On the next edge, load ex_pc/ex_op1/ex_op2/ex_imm/ex_rd/ex_wr_rd/ex_ctrl and set ex_valid=1.
- ex_valid && ex_ready && !issue -> ex_valid=0 next edge; data fields hold.
- ex_valid && !ex_ready -> all ex_* hold stable; dec_ready=0.
- Latency: one cycle decode -> execute. Full throughput when no hazards.
- stall_count increments when dec_valid & ~dec_ready; saturates at 0xFFFFFFFF.
- Writebacks into the regfile arrive strictly in program order per register; this is guaranteed downstream.
- Reset asserted mid-operation: the output register is dropped immediately.

Decomposition:
- Shared package holds:
  - XLEN
  - REG_ZERO=5'd0
  - ctrl bundle field offsets
- One sub-module, operand_bypass: index, regfile data/valid and both write ports in; value and ready out. Instantiated twice.

Test Plan:
- Reset, then decode addi x5 (rs1=x1 valid, data 0x10, imm 4) -> next cycle ex_valid=1, ex_op1=0x10, ex_imm=4; reserve=1 with rd=5 on the issue cycle.
- rs1=x7 with rs1_valid=0, no writeback for 3 cycles -> dec_ready=0 for 3 cycles, stall_count=3. Then wen1=1, wreg1=7, wdata1=0xAB -> issue that cycle, ex_op1=0xAB.
- wen0 (x3=0x11) and wen1 (x3=0x22) both enabled in the same cycle, rs2=x3 -> ex_op2=0x11.
- dec_rd=x9, dec_wr_rd=1, wen0=1 with wreg0=9 -> dec_ready=0 and reserve=0 that cycle; issue next cycle with reserve=1.
- ex_ready=0 for 2 cycles with ex_valid=1 -> ex_* outputs unchanged, dec_ready=0. When ex_ready=1, a new instruction loads on the same edge and ex_valid stays 1.
- rs1=x0, rd=x0 with dec_wr_rd=1 -> op1=0, reserve=0; assert reset while ex_valid=1 -> ex_valid=0 immediately.
